// File: rtl/mac_table_ctrl_if.sv
// Bundle of the MAC table controller's requester, flush and table RAM signals.
//   slave  : the controller view (serves lookup/learn, drives the RAM port)
//   master : the surrounding view (hash units, flush source and the RAM itself)
// Signals: ilkp_* / olkp_* lookup handshake, ilrn_* / olrn_ack learn handshake,
//          iflush / obusy flush control, omem_* / imem_rdata table RAM port.
interface mac_table_ctrl_if #(
    parameter int unsigned pADDR_WIDTH = 14,
    parameter int unsigned pMAC_WIDTH  = 48,
    parameter int unsigned pPORT_WIDTH = 4
);
    localparam int unsigned W = 1 + pPORT_WIDTH + pMAC_WIDTH;

    logic                   ilkp_req;
    logic [pADDR_WIDTH-1:0] ilkp_addr;
    logic [pMAC_WIDTH-1:0]  ilkp_mac;
    logic                   olkp_ack;
    logic                   olkp_hit;
    logic [pPORT_WIDTH-1:0] olkp_port;

    logic                   ilrn_req;
    logic [pADDR_WIDTH-1:0] ilrn_addr;
    logic [pMAC_WIDTH-1:0]  ilrn_mac;
    logic [pPORT_WIDTH-1:0] ilrn_port;
    logic                   olrn_ack;

    logic                   iflush;
    logic                   obusy;

    logic [pADDR_WIDTH-1:0] omem_addr;
    logic                   omem_re;
    logic                   omem_we;
    logic [W-1:0]           omem_wdata;
    logic [W-1:0]           imem_rdata;

    modport slave (
        input  ilkp_req, ilkp_addr, ilkp_mac,
        output olkp_ack, olkp_hit, olkp_port,
        input  ilrn_req, ilrn_addr, ilrn_mac, ilrn_port,
        output olrn_ack,
        input  iflush,
        output obusy,
        output omem_addr, omem_re, omem_we, omem_wdata,
        input  imem_rdata
    );

    modport master (
        output ilkp_req, ilkp_addr, ilkp_mac,
        input  olkp_ack, olkp_hit, olkp_port,
        output ilrn_req, ilrn_addr, ilrn_mac, ilrn_port,
        input  olrn_ack,
        output iflush,
        input  obusy,
        input  omem_addr, omem_re, omem_we, omem_wdata,
        output imem_rdata
    );
endinterface

// File: rtl/mac_table_ctrl.sv
// MAC table controller: sequences a single-port, 1-cycle-read table RAM for
// destination lookups and source learns (round-robin arbitrated), and runs a
// whole-table flush sweep. Entry layout is {valid, port, mac}.
// Ports: iclk, irst_n (async active-low), bus (mac_table_ctrl_if.slave).
module mac_table_ctrl #(
    parameter int unsigned pADDR_WIDTH = 14,
    parameter int unsigned pMAC_WIDTH  = 48,
    parameter int unsigned pPORT_WIDTH = 4
) (
    input  logic              iclk,
    input  logic              irst_n,
    mac_table_ctrl_if.slave   bus
);
    localparam int unsigned W = 1 + pPORT_WIDTH + pMAC_WIDTH;
    localparam logic [pADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        IDLE, LKP_RD, LKP_CMP, LRN_RD, LRN_CMP, LRN_WR, FLUSH
    } state_t;

    state_t                 state_q, state_d;
    logic                   rr_q, rr_d;            // 0: lookup has priority next
    logic                   flush_pend_q, flush_pend_d;
    logic [pADDR_WIDTH-1:0] fl_cnt_q, fl_cnt_d;

    logic                   lkp_ack_q, lkp_ack_d;
    logic                   lkp_hit_q, lkp_hit_d;
    logic [pPORT_WIDTH-1:0] lkp_port_q, lkp_port_d;
    logic                   lrn_ack_q, lrn_ack_d;
    logic                   busy_q, busy_d;
    logic [pADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                   mem_re_q, mem_re_d;
    logic                   mem_we_q, mem_we_d;
    logic [W-1:0]           mem_wdata_q, mem_wdata_d;

    // Fields of the entry returned by the RAM
    logic                   rd_valid;
    logic [pPORT_WIDTH-1:0] rd_port;
    logic [pMAC_WIDTH-1:0]  rd_mac;
    assign rd_valid = bus.imem_rdata[W-1];
    assign rd_port  = bus.imem_rdata[W-2 -: pPORT_WIDTH];
    assign rd_mac   = bus.imem_rdata[pMAC_WIDTH-1:0];

    logic grant_lkp, grant_lrn;

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        flush_pend_d = flush_pend_q | (bus.iflush & ~busy_q);
        fl_cnt_d     = fl_cnt_q;
        lkp_ack_d    = 1'b0;
        lkp_hit_d    = 1'b0;
        lkp_port_d   = '0;
        lrn_ack_d    = 1'b0;
        busy_d       = busy_q;
        mem_addr_d   = mem_addr_q;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_wdata_d  = '0;
        grant_lkp    = 1'b0;
        grant_lrn    = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush_pend_q) begin
                    state_d      = FLUSH;
                    busy_d       = 1'b1;
                    flush_pend_d = 1'b0;
                    fl_cnt_d     = '0;
                    mem_addr_d   = '0;
                    mem_we_d     = 1'b1;
                end else if (!(lkp_ack_q || lrn_ack_q)) begin
                    // Hold off one cycle after an ack so the requester can drop req
                    grant_lkp = bus.ilkp_req & (~bus.ilrn_req | ~rr_q);
                    grant_lrn = bus.ilrn_req & (~bus.ilkp_req |  rr_q);
                    if (grant_lkp) begin
                        state_d    = LKP_RD;
                        mem_addr_d = bus.ilkp_addr;
                        mem_re_d   = 1'b1;
                        rr_d       = ~rr_q;
                    end else if (grant_lrn) begin
                        state_d    = LRN_RD;
                        mem_addr_d = bus.ilrn_addr;
                        mem_re_d   = 1'b1;
                        rr_d       = ~rr_q;
                    end
                end
            end
            LKP_RD: state_d = LKP_CMP;
            LKP_CMP: begin
                lkp_ack_d  = 1'b1;
                lkp_hit_d  = rd_valid && (rd_mac == bus.ilkp_mac);
                lkp_port_d = lkp_hit_d ? rd_port : '0;
                state_d    = IDLE;
            end
            LRN_RD: state_d = LRN_CMP;
            LRN_CMP: begin
                if (rd_valid && (rd_mac == bus.ilrn_mac) && (rd_port == bus.ilrn_port)) begin
                    lrn_ack_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    // Empty slot, moved station or collision: latest learner overwrites
                    mem_we_d    = 1'b1;
                    mem_wdata_d = {1'b1, bus.ilrn_port, bus.ilrn_mac};
                    state_d     = LRN_WR;
                end
            end
            LRN_WR: begin
                lrn_ack_d = 1'b1;
                state_d   = IDLE;
            end
            FLUSH: begin
                fl_cnt_d = fl_cnt_q + pADDR_WIDTH'(1);
                if (fl_cnt_q == LAST_ADDR) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    mem_addr_d = fl_cnt_q + pADDR_WIDTH'(1);
                    mem_we_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q      <= IDLE;
            rr_q         <= 1'b0;
            flush_pend_q <= 1'b0;
            fl_cnt_q     <= '0;
            lkp_ack_q    <= 1'b0;
            lkp_hit_q    <= 1'b0;
            lkp_port_q   <= '0;
            lrn_ack_q    <= 1'b0;
            busy_q       <= 1'b0;
            mem_addr_q   <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            flush_pend_q <= flush_pend_d;
            fl_cnt_q     <= fl_cnt_d;
            lkp_ack_q    <= lkp_ack_d;
            lkp_hit_q    <= lkp_hit_d;
            lkp_port_q   <= lkp_port_d;
            lrn_ack_q    <= lrn_ack_d;
            busy_q       <= busy_d;
            mem_addr_q   <= mem_addr_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.olkp_ack   = lkp_ack_q;
    assign bus.olkp_hit   = lkp_hit_q;
    assign bus.olkp_port  = lkp_port_q;
    assign bus.olrn_ack   = lrn_ack_q;
    assign bus.obusy      = busy_q;
    assign bus.omem_addr  = mem_addr_q;
    assign bus.omem_re    = mem_re_q;
    assign bus.omem_we    = mem_we_q;
    assign bus.omem_wdata = mem_wdata_q;
endmodule
